// File: rtl/digit_separator.sv
// Sequential binary-to-BCD converter that runs one double-dabble iteration per clock.
// Values that need more than DIGITS digits saturate to all nines and raise overflow.
module digit_separator #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      numero,
    input  logic                  update,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic               carry_out;
    logic               ovf_next;

    // Add-3 correction on every working digit, then the combined left shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        carry_out = bcd_adj[BCD_W-1];
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
        ovf_next  = ovf_flag_q | carry_out;
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_flag_d = ovf_flag_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (update) begin
                    bin_d      = numero;
                    bcd_d      = '0;
                    ovf_flag_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bin_d      = bin_q << 1;
                bcd_d      = bcd_shift;
                ovf_flag_d = ovf_next;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    digits_d   = ovf_next ? ALL_NINES : bcd_shift;
                    overflow_d = ovf_next;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_flag_q <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_flag_q <= ovf_flag_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign digits   = digits_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_digit_separator.sv
// Self-checking bench for digit_separator: three configurations (8/3, 8/2, 16/5)
// driven from a directed vector table plus hand-written handshake and reset sequences.
module tb_digit_separator;

    logic clk;
    logic reset;

    logic        upd_a, upd_b, upd_c;
    logic [7:0]  num_a, num_b;
    logic [15:0] num_c;
    logic [11:0] dig_a;
    logic [7:0]  dig_b;
    logic [19:0] dig_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    digit_separator #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .reset(reset), .numero(num_a), .update(upd_a),
        .digits(dig_a), .overflow(ovf_a), .busy(busy_a), .done(done_a)
    );
    digit_separator #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .reset(reset), .numero(num_b), .update(upd_b),
        .digits(dig_b), .overflow(ovf_b), .busy(busy_b), .done(done_b)
    );
    digit_separator #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .reset(reset), .numero(num_c), .update(upd_c),
        .digits(dig_c), .overflow(ovf_c), .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] value;
        logic [19:0] exp_digits;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0:       return ovf_a;
            1:       return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic logic [19:0] get_digits(input int sel);
        case (sel)
            0:       return {8'h00, dig_a};
            1:       return {12'h000, dig_b};
            default: return dig_c;
        endcase
    endfunction

    task automatic drive(input int sel, input logic u, input logic [15:0] v);
        case (sel)
            0:       begin upd_a = u; num_a = v[7:0]; end
            1:       begin upd_b = u; num_b = v[7:0]; end
            default: begin upd_c = u; num_c = v; end
        endcase
    endtask

    // One update pulse; returns result, edges from accept to done, and busy cycle count
    task automatic run(input int sel, input logic [15:0] v,
                       output logic [19:0] dg, output logic ov,
                       output int lat, output int bcnt);
        @(negedge clk);
        drive(sel, 1'b1, v);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, v);
        lat  = 0;
        bcnt = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (get_busy(sel)) bcnt++;
        dg = get_digits(sel);
        ov = get_ovf(sel);
        @(posedge clk);
        @(negedge clk);
        check("done_single_cycle", {31'd0, get_done(sel)}, 32'd0);
        check("idle_after_done", {31'd0, get_busy(sel)}, 32'd0);
    endtask

    logic [19:0] dg;
    logic        ov;
    int          lat, bcnt, n, extra, dn, bad;
    logic        prev;

    initial begin
        vecs[0]  = '{0, 16'd25,    20'h00025, 1'b0, 8};
        vecs[1]  = '{0, 16'd255,   20'h00255, 1'b0, 8};
        vecs[2]  = '{0, 16'd0,     20'h00000, 1'b0, 8};
        vecs[3]  = '{0, 16'd100,   20'h00100, 1'b0, 8};
        vecs[4]  = '{0, 16'd199,   20'h00199, 1'b0, 8};
        vecs[5]  = '{1, 16'd99,    20'h00099, 1'b0, 8};
        vecs[6]  = '{1, 16'd100,   20'h00099, 1'b1, 8};
        vecs[7]  = '{1, 16'd255,   20'h00099, 1'b1, 8};
        vecs[8]  = '{1, 16'd9,     20'h00009, 1'b0, 8};
        vecs[9]  = '{2, 16'd65535, 20'h65535, 1'b0, 16};
        vecs[10] = '{2, 16'd0,     20'h00000, 1'b0, 16};
        vecs[11] = '{2, 16'd10000, 20'h10000, 1'b0, 16};

        reset = 1'b1;
        upd_a = 1'b0; upd_b = 1'b0; upd_c = 1'b0;
        num_a = '0;   num_b = '0;   num_c = '0;
        repeat (3) @(negedge clk);
        check("reset_digits_a", {20'd0, dig_a}, 32'd0);
        check("reset_ovf_b", {31'd0, ovf_b}, 32'd0);
        check("reset_busy_c", {31'd0, busy_c}, 32'd0);
        check("reset_done_a", {31'd0, done_a}, 32'd0);
        reset = 1'b0;

        // Directed table across all three configurations
        for (int i = 0; i < 12; i++) begin
            run(vecs[i].sel, vecs[i].value, dg, ov, lat, bcnt);
            check($sformatf("vec%0d_digits", i), {12'd0, dg}, {12'd0, vecs[i].exp_digits});
            check($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat + 1);
        end

        // Sweep 0..99 on the default configuration
        for (int i = 0; i < 100; i++) begin
            run(0, 16'(i), dg, ov, lat, bcnt);
            check($sformatf("sweep%0d_digits", i), {12'd0, dg},
                  32'((i / 10) * 16 + (i % 10)));
            check($sformatf("sweep%0d_ovf", i), {31'd0, ov}, 32'd0);
        end

        // update re-pulsed mid-conversion and during DONE, numero changed after accept
        @(negedge clk); upd_a = 1'b1; num_a = 8'd40;
        @(posedge clk);
        @(negedge clk); upd_a = 1'b0; num_a = 8'd77;
        @(posedge clk); @(posedge clk);
        @(negedge clk); upd_a = 1'b1;
        @(posedge clk);
        @(negedge clk); upd_a = 1'b0;
        n = 0;
        while (!done_a && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("busy_rules_done_seen", {31'd0, done_a}, 32'd1);
        check("busy_rules_latency", n, 5);
        check("busy_rules_digits", {20'd0, dig_a}, 32'h040);
        upd_a = 1'b1;
        @(posedge clk);
        @(negedge clk); upd_a = 1'b0;
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) extra++;
        end
        check("busy_rules_no_second_done", extra, 0);

        // update held high: repeated conversions, never two done cycles in a row
        @(negedge clk); upd_a = 1'b1; num_a = 8'd123;
        dn = 0; bad = 0; prev = 1'b0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) begin
                dn++;
                if (dig_a !== 12'h123) bad++;
                if (prev) bad++;
            end
            prev = done_a;
        end
        upd_a = 1'b0;
        check("hold_high_done_count", dn, 6);
        check("hold_high_bad_results", bad, 0);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk); upd_a = 1'b1; num_a = 8'd25;
        @(posedge clk);
        @(negedge clk); upd_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", {31'd0, busy_a}, 32'd0);
        check("midreset_done", {31'd0, done_a}, 32'd0);
        check("midreset_digits", {20'd0, dig_a}, 32'd0);
        check("midreset_ovf_b", {31'd0, ovf_b}, 32'd0);
        @(negedge clk); reset = 1'b0;
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) extra++;
        end
        check("midreset_no_done", extra, 0);
        run(0, 16'd7, dg, ov, lat, bcnt);
        check("post_reset_digits", {12'd0, dg}, 32'h007);
        check("post_reset_ovf", {31'd0, ov}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
